// File: rtl/hdmi_island_pkg.sv
// Shared timing constants, phase encoding and FSM state type for the HDMI data-island schedulers.
package hdmi_island_pkg;

    localparam int PREAMBLE_LEN = 8;
    localparam int GUARD_LEN    = 2;
    localparam int PACKET_LEN   = 32;
    localparam int CTRL_GAP_MIN = 12;

    // Wide enough to count every cycle of the longest phase (the packet).
    localparam int PHASE_CNT_W  = $clog2(PACKET_LEN);

    localparam logic [1:0] PHASE_PREAMBLE = 2'd0;
    localparam logic [1:0] PHASE_GUARD    = 2'd1;
    localparam logic [1:0] PHASE_PACKET   = 2'd2;
    localparam logic [1:0] PHASE_IDLE     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_LEAD_GUARD,
        ST_PACKET,
        ST_TRAIL_GUARD
    } state_t;

endpackage

// File: rtl/vblank_island_scheduler_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting index at or above the pointer, wrapping.
module round_robin_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] request,
    input  logic [W-1:0] pointer,
    output logic [W-1:0] grant,
    output logic         valid
);

    always_comb begin
        grant = '0;
        valid = |request;
        // Walk from the farthest offset down so the nearest hit overwrites the rest.
        for (int i = N - 1; i >= 0; i--) begin
            int idx;
            idx = (int'(pointer) + i) % N;
            if (request[idx]) begin
                grant = W'(idx);
            end
        end
    end

endmodule

// File: rtl/vblank_island_scheduler.sv
// VBlank InfoFrame island sequencer and source arbiter.
// Optional feature: VBLANK_SCHED_ONCE_PER_FRAME_EN limits every source to one packet per frame.
module vblank_island_scheduler
    import hdmi_island_pkg::*;
#(
    parameter int NUM_SOURCES  = 4,
    parameter int MAX_PACKETS  = 2,
    parameter int WINDOW_START = 104,
    parameter int WINDOW_END   = 200,
    parameter int LINE_CNT_W   = 12
) (
    input  logic                           pixelClock,
    input  logic                           reset,
    input  logic                           hSync,
    input  logic                           vBlank,
    input  logic [NUM_SOURCES-1:0]         req,
    output logic [NUM_SOURCES-1:0]         ack,
    output logic                           islandActive,
    output logic [1:0]                     phase,
    output logic                           packetStart,
    output logic                           firstPacket,
    output logic [$clog2(NUM_SOURCES)-1:0] grantIndex,
    output logic                           overrun
);

    localparam int IDX_W = $clog2(NUM_SOURCES);
    localparam int PKT_W = $clog2(MAX_PACKETS + 1);

    if (WINDOW_START + PREAMBLE_LEN + GUARD_LEN + PACKET_LEN + GUARD_LEN > WINDOW_END) begin : gWindowTooSmall
        $error("vblank_island_scheduler: a single-packet island does not fit between WINDOW_START and WINDOW_END");
    end

    state_t                   state;
    logic [PHASE_CNT_W-1:0]   phaseCnt;
    logic [PKT_W-1:0]         packetCount;
    logic [IDX_W-1:0]         rrPointer;
    logic [LINE_CNT_W-1:0]    lineCount;
    logic                     hSyncDly;
    logic                     hSyncRise;
    logic [NUM_SOURCES-1:0]   eligible;
    logic [NUM_SOURCES-1:0]   grantOneHot;
    logic [NUM_SOURCES-1:0]   arbRequest;
    logic [IDX_W-1:0]         nextPointer;
    logic [IDX_W-1:0]         arbPointer;
    logic [IDX_W-1:0]         arbGrant;
    logic                     arbValid;
    logic                     roomForPacket;

    assign hSyncRise = hSync & ~hSyncDly;

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            hSyncDly  <= 1'b0;
            lineCount <= '1;
        end else begin
            hSyncDly <= hSync;
            if (hSyncRise) begin
                lineCount <= '0;
            end else if (lineCount != '1) begin
                lineCount <= lineCount + LINE_CNT_W'(1);
            end
        end
    end

`ifdef VBLANK_SCHED_ONCE_PER_FRAME_EN
    logic                   vBlankDly;
    logic [NUM_SOURCES-1:0] served;

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            vBlankDly <= 1'b0;
        end else begin
            vBlankDly <= vBlank;
        end
    end

    for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : gServed
        logic servedBit;
        always_ff @(posedge pixelClock) begin
            if (reset) begin
                servedBit <= 1'b0;
            end else if (ack[gi]) begin
                servedBit <= 1'b1;
            end else if (vBlank && !vBlankDly) begin
                servedBit <= 1'b0;
            end
        end
        assign served[gi] = servedBit;
    end

    assign eligible = req & ~served;
`else
    assign eligible = req;
`endif

    assign grantOneHot = NUM_SOURCES'(1) << grantIndex;
    assign nextPointer = (int'(grantIndex) == NUM_SOURCES - 1) ? '0 : grantIndex + IDX_W'(1);

    // While a packet is finishing, re-arbitrate from just past the current grant and skip it.
    assign arbRequest = (state == ST_PACKET) ? (eligible & ~grantOneHot) : eligible;
    assign arbPointer = (state == ST_PACKET) ? nextPointer : rrPointer;

    // Another packet plus the trailing guard must finish by WINDOW_END.
    assign roomForPacket = (int'(lineCount) + 1 + PACKET_LEN + GUARD_LEN) <= WINDOW_END;

    round_robin_arbiter #(
        .N(NUM_SOURCES)
    ) uArbiter (
        .request(arbRequest),
        .pointer(arbPointer),
        .grant  (arbGrant),
        .valid  (arbValid)
    );

    always_ff @(posedge pixelClock) begin
        if (reset) begin
            state        <= ST_IDLE;
            phaseCnt     <= '0;
            packetCount  <= '0;
            rrPointer    <= '0;
            grantIndex   <= '0;
            ack          <= '0;
            islandActive <= 1'b0;
            phase        <= PHASE_IDLE;
            packetStart  <= 1'b0;
            firstPacket  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            ack         <= '0;
            packetStart <= 1'b0;
            if (state != ST_IDLE && hSyncRise) begin
                state        <= ST_IDLE;
                phaseCnt     <= '0;
                islandActive <= 1'b0;
                phase        <= PHASE_IDLE;
                firstPacket  <= 1'b0;
                overrun      <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (lineCount == LINE_CNT_W'(WINDOW_START) && vBlank && arbValid && !hSyncRise) begin
                            state        <= ST_PREAMBLE;
                            phaseCnt     <= '0;
                            packetCount  <= '0;
                            grantIndex   <= arbGrant;
                            islandActive <= 1'b1;
                            phase        <= PHASE_PREAMBLE;
                        end
                    end
                    ST_PREAMBLE: begin
                        phaseCnt <= phaseCnt + PHASE_CNT_W'(1);
                        if (phaseCnt == PHASE_CNT_W'(PREAMBLE_LEN - 1)) begin
                            state    <= ST_LEAD_GUARD;
                            phaseCnt <= '0;
                            phase    <= PHASE_GUARD;
                        end
                    end
                    ST_LEAD_GUARD: begin
                        phaseCnt <= phaseCnt + PHASE_CNT_W'(1);
                        if (phaseCnt == PHASE_CNT_W'(GUARD_LEN - 1)) begin
                            state       <= ST_PACKET;
                            phaseCnt    <= '0;
                            phase       <= PHASE_PACKET;
                            packetStart <= 1'b1;
                            firstPacket <= 1'b1;
                            packetCount <= PKT_W'(1);
                        end
                    end
                    ST_PACKET: begin
                        phaseCnt <= phaseCnt + PHASE_CNT_W'(1);
                        // Registered ack lands on the packet's last cycle.
                        if (phaseCnt == PHASE_CNT_W'(PACKET_LEN - 2)) begin
                            ack <= grantOneHot;
                        end
                        if (phaseCnt == PHASE_CNT_W'(PACKET_LEN - 1)) begin
                            rrPointer   <= nextPointer;
                            firstPacket <= 1'b0;
                            phaseCnt    <= '0;
                            if (arbValid && int'(packetCount) < MAX_PACKETS && roomForPacket) begin
                                grantIndex  <= arbGrant;
                                packetStart <= 1'b1;
                                packetCount <= packetCount + PKT_W'(1);
                            end else begin
                                state <= ST_TRAIL_GUARD;
                                phase <= PHASE_GUARD;
                            end
                        end
                    end
                    ST_TRAIL_GUARD: begin
                        phaseCnt <= phaseCnt + PHASE_CNT_W'(1);
                        if (phaseCnt == PHASE_CNT_W'(GUARD_LEN - 1)) begin
                            state        <= ST_IDLE;
                            phaseCnt     <= '0;
                            islandActive <= 1'b0;
                            phase        <= PHASE_IDLE;
                        end
                    end
                    default: begin
                        state        <= ST_IDLE;
                        phaseCnt     <= '0;
                        islandActive <= 1'b0;
                        phase        <= PHASE_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vblank_island_scheduler.sv
// Scoreboard bench for vblank_island_scheduler: a default instance and a WINDOW_END=170 instance.
module tb_vblank_island_scheduler;

    localparam int LINE_LEN = 240;
`ifdef VBLANK_SCHED_ONCE_PER_FRAME_EN
    localparam bit ONCE = 1'b1;
`else
    localparam bit ONCE = 1'b0;
`endif

    logic       pixelClock = 1'b0;
    logic       reset = 1'b1;
    logic       hSync = 1'b0;
    logic       vBlank = 1'b0;
    logic [3:0] reqA = '0;
    logic [3:0] reqB = '0;
    logic [3:0] ackA, ackB;
    logic       activeA, activeB, pktStartA, pktStartB, firstA, firstB, overrunA, overrunB;
    logic [1:0] phaseA, phaseB, grantA, grantB;

    typedef struct {
        int src;
        int line;
    } ackExp_t;

    ackExp_t sbA[$];
    ackExp_t sbB[$];

    int nChecks = 0;
    int nFail = 0;
    int tbLine = 4095;
    bit pendingRise = 1'b0;
    bit aborted = 1'b0;
    int scen = 0;
    int lineIdx = 0;

    always #5 pixelClock = ~pixelClock;

    vblank_island_scheduler dutA (
        .pixelClock(pixelClock), .reset(reset), .hSync(hSync), .vBlank(vBlank),
        .req(reqA), .ack(ackA), .islandActive(activeA), .phase(phaseA),
        .packetStart(pktStartA), .firstPacket(firstA), .grantIndex(grantA), .overrun(overrunA)
    );

    vblank_island_scheduler #(.WINDOW_END(170)) dutB (
        .pixelClock(pixelClock), .reset(reset), .hSync(hSync), .vBlank(vBlank),
        .req(reqB), .ack(ackB), .islandActive(activeB), .phase(phaseB),
        .packetStart(pktStartB), .firstPacket(firstB), .grantIndex(grantB), .overrun(overrunB)
    );

    task automatic checkValue(input string tag, input int got, input int exp);
        nChecks++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0d, expected %0d (line cycle %0d)", tag, got, exp, tbLine);
        end
    endtask

    task automatic observe();
        ackExp_t e;
        for (int s = 0; s < 4; s++) begin
            if (ackA[s]) begin
                $display("ack dutA src=%0d line=%0d", s, tbLine);
                checkValue("ackA_expected", int'(sbA.size() > 0), 1);
                if (sbA.size() > 0) begin
                    e = sbA.pop_front();
                    checkValue("ackA_src", s, e.src);
                    checkValue("ackA_line", tbLine, e.line);
                end
                reqA[s] = 1'b0;
            end
            if (ackB[s]) begin
                $display("ack dutB src=%0d line=%0d", s, tbLine);
                checkValue("ackB_expected", int'(sbB.size() > 0), 1);
                if (sbB.size() > 0) begin
                    e = sbB.pop_front();
                    checkValue("ackB_src", s, e.src);
                    checkValue("ackB_line", tbLine, e.line);
                end
                reqB[s] = 1'b0;
            end
        end
        if (scen == 1 && lineIdx == 0) begin
            case (tbLine)
                104: begin checkValue("s1_active_104", int'(activeA), 0); checkValue("s1_phase_104", int'(phaseA), 3); end
                105: begin checkValue("s1_active_105", int'(activeA), 1); checkValue("s1_phase_105", int'(phaseA), 0); end
                112: checkValue("s1_phase_112", int'(phaseA), 0);
                113: checkValue("s1_phase_113", int'(phaseA), 1);
                114: begin checkValue("s1_phase_114", int'(phaseA), 1); checkValue("s1_pstart_114", int'(pktStartA), 0); end
                115: begin
                    checkValue("s1_phase_115", int'(phaseA), 2);
                    checkValue("s1_pstart_115", int'(pktStartA), 1);
                    checkValue("s1_first_115", int'(firstA), 1);
                    checkValue("s1_grant_115", int'(grantA), 0);
                end
                116: checkValue("s1_pstart_116", int'(pktStartA), 0);
                147: checkValue("s1_phase_147", int'(phaseA), 1);
                148: checkValue("s1_active_148", int'(activeA), 1);
                149: begin checkValue("s1_active_149", int'(activeA), 0); checkValue("s1_phase_149", int'(phaseA), 3); end
                default: ;
            endcase
        end
        if (scen == 2 && lineIdx == 0) begin
            case (tbLine)
                147: begin
                    checkValue("s2_pstart_147", int'(pktStartA), 1);
                    checkValue("s2_grant_147", int'(grantA), 1);
                    checkValue("s2_first_147", int'(firstA), 0);
                    checkValue("s2B_phase_147", int'(phaseB), 1);
                end
                149: checkValue("s2B_active_149", int'(activeB), 0);
                180: checkValue("s2_active_180", int'(activeA), 1);
                181: checkValue("s2_active_181", int'(activeA), 0);
                default: ;
            endcase
        end
        if (scen == 3 && aborted && tbLine == 0) begin
            checkValue("s3_active_after_abort", int'(activeA), 0);
            checkValue("s3_phase_after_abort", int'(phaseA), 3);
            checkValue("s3_overrun_after_abort", int'(overrunA), 1);
        end
        if (scen == 4 && (tbLine == 105 || tbLine == 115 || tbLine == 146)) begin
            checkValue("s4_activeA", int'(activeA), 0);
            checkValue("s4_activeB", int'(activeB), 0);
        end
    endtask

    task automatic cycle();
        @(posedge pixelClock);
        if (pendingRise) begin
            tbLine = 0;
            pendingRise = 1'b0;
        end else if (tbLine < 4095) begin
            tbLine++;
        end
        @(negedge pixelClock);
        observe();
    endtask

    // One line started by an hSync rise; abortAt >= 0 raises hSync again mid-line.
    task automatic runLine(input int abortAt);
        hSync = 1'b1;
        pendingRise = 1'b1;
        aborted = 1'b0;
        do begin
            cycle();
            if (tbLine == 3) hSync = 1'b0;
            if (!aborted && tbLine == abortAt) begin
                hSync = 1'b1;
                pendingRise = 1'b1;
                aborted = 1'b1;
            end
        end while (!(tbLine == LINE_LEN - 1 && !pendingRise));
    endtask

    task automatic doReset();
        scen = 0;
        reset = 1'b1;
        hSync = 1'b0;
        vBlank = 1'b0;
        reqA = '0;
        reqB = '0;
        repeat (3) cycle();
        checkValue("rst_ack", int'(ackA), 0);
        checkValue("rst_active", int'(activeA), 0);
        checkValue("rst_phase", int'(phaseA), 3);
        checkValue("rst_pstart", int'(pktStartA), 0);
        checkValue("rst_first", int'(firstA), 0);
        checkValue("rst_grant", int'(grantA), 0);
        checkValue("rst_overrunA", int'(overrunA), 0);
        checkValue("rst_overrunB", int'(overrunB), 0);
        reset = 1'b0;
        tbLine = 4095;
        pendingRise = 1'b0;
    endtask

    task automatic checkDrained(input string tag);
        checkValue({tag, "_sbA_empty"}, sbA.size(), 0);
        checkValue({tag, "_sbB_empty"}, sbB.size(), 0);
        sbA.delete();
        sbB.delete();
    endtask

    initial begin
        // Single-packet island timing.
        doReset();
        scen = 1; lineIdx = 0;
        vBlank = 1'b1; reqA = 4'b0001; reqB = 4'b0001;
        sbA.push_back('{src: 0, line: 146});
        sbB.push_back('{src: 0, line: 146});
        runLine(-1);
        checkDrained("s1");

        // Two packets per island; narrow window on dutB forces a single packet.
        doReset();
        scen = 2; lineIdx = 0;
        vBlank = 1'b1; reqA = 4'b1011; reqB = 4'b0011;
        sbA.push_back('{src: 0, line: 146});
        sbA.push_back('{src: 1, line: 178});
        sbB.push_back('{src: 0, line: 146});
        runLine(-1);
        lineIdx = 1;
        sbA.push_back('{src: 3, line: 146});
        sbB.push_back('{src: 1, line: 146});
        runLine(-1);
        checkDrained("s2");

        // hSync mid-packet aborts; request still pending is served on the new line.
        doReset();
        scen = 3; lineIdx = 0;
        vBlank = 1'b1; reqA = 4'b0001; reqB = 4'b0000;
        sbA.push_back('{src: 0, line: 146});
        runLine(130);
        checkValue("s3_overrun_held", int'(overrunA), 1);
        checkValue("s3_overrunB_clear", int'(overrunB), 0);
        checkDrained("s3");

        // No island outside vertical blanking.
        doReset();
        scen = 4; lineIdx = 0;
        vBlank = 1'b0; reqA = 4'b1111; reqB = 4'b1111;
        runLine(-1);
        checkDrained("s4");

        // Repeated requests across blanking lines and a new frame.
        doReset();
        scen = 5;
        for (int l = 0; l < 4; l++) begin
            lineIdx = l;
            vBlank = (l != 2);
            reqA = reqA | 4'b0001;
            reqB = 4'b0000;
            if (l == 0 || l == 3 || (l == 1 && !ONCE)) begin
                sbA.push_back('{src: 0, line: 146});
            end
            runLine(-1);
        end
        checkDrained("s5");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/vblank_island_scheduler.md
# vblank_island_scheduler

Sequences InfoFrame data islands during vertical blanking and arbitrates between the InfoFrame packet sources (AVI, Audio InfoFrame, SPD, vendor-specific) that share the single VBlank island serializer. It opens a window only after the HBlank audio island has finished, so both islands never overlap on the same line. It tells the serializer/encoder which phase to emit and which source's packet to mux in. Requesters are handshaked with a level request and a one-cycle acknowledge.

## Interface
Parameters:
- NUM_SOURCES, 4: number of packet requesters (2..8).
- MAX_PACKETS, 2: maximum packets per island (1..18).
- WINDOW_START, 104: line cycle count at which an island may start (HBlank island end 92 + 12-cycle control gap).
- WINDOW_END, 200: line cycle count by which the trailing guard band must have completed.
- LINE_CNT_W, 12: width of the line cycle counter.

Ports:
- pixelClock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- hSync  in  1  horizontal sync, active-high.
- vBlank  in  1  high during vertical blanking lines.
- req  in  NUM_SOURCES  level request per source; held until acked.
- ack  out  NUM_SOURCES  one-cycle pulse on the last cycle of the source's packet.
- islandActive  out  1  high for preamble through trailing guard band.
- phase  out  2  0 preamble, 1 guard band, 2 packet, 3 idle.
- packetStart  out  1  pulse on the first cycle of each 32-cycle packet; drives the serializer's first-clock input.
- firstPacket  out  1  high throughout the island's first packet.
- grantIndex  out  $clog2(NUM_SOURCES)  source whose packet is being sent; valid while phase==2.
- overrun  out  1  sticky; set when an island is aborted by hSync.

## Operation
- Reset values: ack=0, islandActive=0, phase=3, packetStart=0, firstPacket=0, grantIndex=0, overrun=0. Also: lineCount=all-ones, round-robin pointer=0, state IDLE.
- lineCount: set to 0 on the cycle after an hSync rising edge (registered edge detect). Otherwise it increments and saturates at its maximum.
- Eligible request set: req, masked as described under Configuration.
- States:
  - IDLE: go to PREAMBLE when lineCount==WINDOW_START, vBlank=1, and the eligible set is non-empty. Lock the round-robin choice into grantIndex at this point.
  - PREAMBLE: 8 cycles, then LEAD_GUARD.
  - LEAD_GUARD: 2 cycles, then PACKET.
  - PACKET: 32 cycles. On cycle 31, pulse ack for grantIndex and advance the pointer to grantIndex+1 (mod NUM_SOURCES). Then:
    - Start another PACKET if an eligible request remains (excluding the source just acked), the packets sent so far < MAX_PACKETS, and lineCount+1+32+2 <= WINDOW_END. Re-arbitrate grantIndex.
    - Otherwise go to TRAIL_GUARD.
  - TRAIL_GUARD: 2 cycles, then IDLE.
- Round robin: lowest eligible index at or above the pointer, with wrap-around.
- Elaboration error if WINDOW_START+44 > WINDOW_END (a single-packet island cannot fit).
- An hSync rising edge while not IDLE aborts the island: next cycle is IDLE, islandActive=0, no ack, overrun=1. overrun clears only on reset.
- A request dropped mid-packet is ignored; ack is still pulsed.
- A vBlank fall mid-island does not stop the island.

## Timing
- All outputs are registered. islandActive, phase and packetStart change on the clock edge where the state changes.
- With the start condition at lineCount==WINDOW_START, the first preamble cycle is WINDOW_START+1.
- First packetStart is 11 cycles after the start decision.
- ack to req-deassert: a source must drop req within 1 cycle of ack, or it is treated as a new request.
- Reset asserted mid-island: all outputs take their reset values on the next edge; the in-flight packet is never acked.

## Configuration
- VBLANK_SCHED_ONCE_PER_FRAME_EN defined: each source is served at most once per frame. A per-source served mask is set on ack and cleared on the vBlank rising edge; the eligible set is req & ~served.
- Not defined: the eligible set is req, and a source may be served on every blanking line.

## Structure
- Package hdmi_island_pkg holds:
  - PREAMBLE_LEN=8, GUARD_LEN=2, PACKET_LEN=32, CTRL_GAP_MIN=12.
  - The phase encoding constants.
  - The state enum typedef.
- Sub-module round_robin_arbiter (parameter N): inputs request vector and pointer; outputs grant index and valid. It is purely combinational and instantiated once.

## Test plan
- Reset, then vBlank=1 with req=4'b0001 → preamble on cycles 105–112, guard 113–114, packetStart at 115, ack[0] at 146, trailing guard 147–148, islandActive low at 149.
- req=4'b1011, MAX_PACKETS=2 → first island sends sources 0 then 1, acks 32 cycles apart; the next line sends source 3.
- WINDOW_END=170 with req=4'b0011 → one packet only; the second request waits for the next line.
- hSync rising at lineCount 130 mid-packet → islandActive=0 next cycle, no ack, overrun=1 and held.
- With VBLANK_SCHED_ONCE_PER_FRAME_EN defined, req=4'b0001 held across a blanking period → one ack per frame; served again after the next vBlank rise.
- vBlank=0 with req=4'b1111 → no island and no ack for an entire line.
